// File: rtl/digit_entry_pkg.sv
// Shared constants, state encoding and helpers for the digit_entry keypad block.
// Optional backspace support is enabled with DIGIT_ENTRY_BKSP_EN.
package digit_entry_pkg;

    localparam int NUM_DIGITS              = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam logic [3:0] MAX_BCD     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // The state is fully determined by how many digits are held.
    function automatic state_t state_for_count(input logic [2:0] count);
        state_t st;
        case (count)
            3'd0:             st = ST_IDLE;
            3'd1, 3'd2, 3'd3: st = ST_ENTRY;
            3'd4:             st = ST_FULL;
            default:          st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/digit_entry_if.sv
// Front-panel bus of digit_entry: switches and keys in, BCD digits and status out.
// KEY_BKSP_N exists only when DIGIT_ENTRY_BKSP_EN is defined.
interface digit_entry_if;

    logic [3:0] SW;
    logic       KEY_ENTER_N;
    logic       KEY_CLEAR_N;
`ifdef DIGIT_ENTRY_BKSP_EN
    logic       KEY_BKSP_N;
`endif
    logic [3:0] DIG0;
    logic [3:0] DIG1;
    logic [3:0] DIG2;
    logic [3:0] DIG3;
    logic [2:0] COUNT;
    logic       FULL;
    logic       DONE;
    logic       ERR;

    modport master (
        output SW,
        output KEY_ENTER_N,
        output KEY_CLEAR_N,
`ifdef DIGIT_ENTRY_BKSP_EN
        output KEY_BKSP_N,
`endif
        input  DIG0,
        input  DIG1,
        input  DIG2,
        input  DIG3,
        input  COUNT,
        input  FULL,
        input  DONE,
        input  ERR
    );

    modport slave (
        input  SW,
        input  KEY_ENTER_N,
        input  KEY_CLEAR_N,
`ifdef DIGIT_ENTRY_BKSP_EN
        input  KEY_BKSP_N,
`endif
        output DIG0,
        output DIG1,
        output DIG2,
        output DIG3,
        output COUNT,
        output FULL,
        output DONE,
        output ERR
    );

endinterface

// File: rtl/digit_entry_key_debounce.sv
// Key conditioning: 2-flop synchronizer, stability-count debouncer and a
// single-cycle press event on each accepted high-to-low level change.
module key_debounce
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/digit_entry.sv
// Calculator-style 4-digit BCD entry: debounced keys drive a digit shift
// register and IDLE/ENTRY/FULL FSM. Backspace key under DIGIT_ENTRY_BKSP_EN.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    digit_entry_if.slave bus
);

    logic enter_s;
    logic clear_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n(bus.KEY_ENTER_N), .press(enter_s)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n(bus.KEY_CLEAR_N), .press(clear_s)
    );
`ifdef DIGIT_ENTRY_BKSP_EN
    logic bksp_s;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bksp (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n(bus.KEY_BKSP_N), .press(bksp_s)
    );
`endif

    state_t                          state_r;
    state_t                          state_nx;
    logic [NUM_DIGITS-1:0][3:0]      dig_r;
    logic [NUM_DIGITS-1:0][3:0]      dig_nx;
    logic [2:0]                      count_r;
    logic [2:0]                      count_nx;
    logic                            full_r;
    logic                            done_r;
    logic                            done_nx;
    logic                            err_r;
    logic                            err_nx;

    // Next-state logic; priority is clear, then backspace, then enter.
    always_comb begin
        state_nx = state_r;
        dig_nx   = dig_r;
        count_nx = count_r;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        if (clear_s) begin
            dig_nx   = {NUM_DIGITS{BLANK_DIGIT}};
            count_nx = 3'd0;
            state_nx = ST_IDLE;
`ifdef DIGIT_ENTRY_BKSP_EN
        end else if (bksp_s) begin
            if (count_r != 3'd0) begin
                dig_nx   = {BLANK_DIGIT, dig_r[NUM_DIGITS-1:1]};
                count_nx = count_r - 3'd1;
                state_nx = state_for_count(count_nx);
            end else begin
                state_nx = state_r;
            end
`endif
        end else if (enter_s) begin
            if (bus.SW > MAX_BCD) begin
                err_nx = 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE, ST_ENTRY: begin
                        dig_nx   = {dig_r[NUM_DIGITS-2:0], bus.SW};
                        count_nx = count_r + 3'd1;
                        state_nx = state_for_count(count_nx);
                        done_nx  = (count_nx == 3'd4);
                    end
                    ST_FULL: state_nx = ST_FULL;
                    default: state_nx = state_for_count(count_r);
                endcase
            end
        end else begin
            state_nx = state_r;
        end
    end

    // State, digit and status registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            dig_r   <= {NUM_DIGITS{BLANK_DIGIT}};
            count_r <= 3'd0;
            full_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            dig_r   <= dig_nx;
            count_r <= count_nx;
            full_r  <= (count_nx == 3'd4);
            done_r  <= done_nx;
            err_r   <= err_nx;
        end
    end

    assign bus.DIG0  = dig_r[0];
    assign bus.DIG1  = dig_r[1];
    assign bus.DIG2  = dig_r[2];
    assign bus.DIG3  = dig_r[3];
    assign bus.COUNT = count_r;
    assign bus.FULL  = full_r;
    assign bus.DONE  = done_r;
    assign bus.ERR   = err_r;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with DEBOUNCE_CYCLES = 4 (key-to-update latency 7 clocks).
// Backspace checks are compiled in with DIGIT_ENTRY_BKSP_EN.
module tb_digit_entry;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    digit_entry_if bus ();

    digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int done_cyc  = 0;
    int press_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.DONE === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.ERR === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] digs();
        return {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0};
    endfunction

    task automatic set_key(input int which, input logic v);
        case (which)
            0: bus.KEY_ENTER_N = v;
            1: bus.KEY_CLEAR_N = v;
`ifdef DIGIT_ENTRY_BKSP_EN
            2: bus.KEY_BKSP_N = v;
`endif
            default: ;
        endcase
    endtask

    // Clean press: key low 10 clocks, then released 10 clocks.
    task automatic press(input int which, input logic [3:0] sw);
        @(negedge clk);
        bus.SW = sw;
        set_key(which, 1'b0);
        press_cyc = cyc;
        repeat (10) @(negedge clk);
        set_key(which, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bus.SW          = 4'd0;
        bus.KEY_ENTER_N = 1'b1;
        bus.KEY_CLEAR_N = 1'b1;
`ifdef DIGIT_ENTRY_BKSP_EN
        bus.KEY_BKSP_N  = 1'b1;
`endif
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_digits", 32'(digs()), 32'hFFFF);
        check_eq("rst_count", 32'(bus.COUNT), 32'd0);
        check_eq("rst_full", 32'(bus.FULL), 32'd0);
        check_eq("rst_done", 32'(bus.DONE), 32'd0);
        check_eq("rst_err", 32'(bus.ERR), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fill with 6,1,4,5
        press(0, 4'd6);
        press(0, 4'd1);
        press(0, 4'd4);
        check_eq("count3", 32'(bus.COUNT), 32'd3);
        check_eq("full_low", 32'(bus.FULL), 32'd0);
        press(0, 4'd5);
        check_eq("fill_digits", 32'(digs()), 32'h6145);
        check_eq("fill_count", 32'(bus.COUNT), 32'd4);
        check_eq("fill_full", 32'(bus.FULL), 32'd1);
        check_eq("done_once", 32'(done_cnt), 32'd1);
        check_eq("done_latency", 32'(done_cyc - press_cyc), 32'd7);

        // Valid enter while full is ignored
        press(0, 4'd3);
        check_eq("full_ign_digits", 32'(digs()), 32'h6145);
        check_eq("full_ign_count", 32'(bus.COUNT), 32'd4);
        check_eq("full_ign_done", 32'(done_cnt), 32'd1);
        check_eq("full_ign_err", 32'(err_cnt), 32'd0);

        press(1, 4'd0);
        check_eq("clr_digits", 32'(digs()), 32'hFFFF);
        check_eq("clr_count", 32'(bus.COUNT), 32'd0);
        check_eq("clr_full", 32'(bus.FULL), 32'd0);

        // Invalid digit with two held
        press(0, 4'd2);
        press(0, 4'd7);
        press(0, 4'hC);
        check_eq("err_pulse", 32'(err_cnt), 32'd1);
        check_eq("err_count", 32'(bus.COUNT), 32'd2);
        check_eq("err_digits", 32'(digs()), 32'hFF27);
        check_eq("err_no_done", 32'(done_cnt), 32'd1);

        // Bouncing enter: low 2, high 1, then held low
        @(negedge clk);
        bus.SW = 4'd8;
        bus.KEY_ENTER_N = 1'b0;
        repeat (2) @(negedge clk);
        bus.KEY_ENTER_N = 1'b1;
        @(negedge clk);
        bus.KEY_ENTER_N = 1'b0;
        repeat (6) @(posedge clk);
        #1 check_eq("bounce_early", 32'(bus.COUNT), 32'd2);
        @(posedge clk);
        #1 check_eq("bounce_accept", 32'(bus.COUNT), 32'd3);
        repeat (100) @(negedge clk);
        check_eq("hold_no_repeat", 32'(bus.COUNT), 32'd3);
        check_eq("hold_digits", 32'(digs()), 32'hF278);
        bus.KEY_ENTER_N = 1'b1;
        repeat (10) @(negedge clk);

        // Clear and enter in the same cycle
        @(negedge clk);
        bus.SW = 4'd5;
        bus.KEY_ENTER_N = 1'b0;
        bus.KEY_CLEAR_N = 1'b0;
        repeat (12) @(negedge clk);
        bus.KEY_ENTER_N = 1'b1;
        bus.KEY_CLEAR_N = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("tie_count", 32'(bus.COUNT), 32'd0);
        check_eq("tie_digits", 32'(digs()), 32'hFFFF);
        check_eq("tie_no_err", 32'(err_cnt), 32'd1);
        check_eq("tie_no_done", 32'(done_cnt), 32'd1);

        // Reset in the middle of a debounce
        press(0, 4'd1);
        press(0, 4'd2);
        check_eq("pre_rst_count", 32'(bus.COUNT), 32'd2);
        @(negedge clk);
        bus.SW = 4'd9;
        bus.KEY_ENTER_N = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_count", 32'(bus.COUNT), 32'd0);
        check_eq("async_rst_digits", 32'(digs()), 32'hFFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_eq("post_rst_early", 32'(bus.COUNT), 32'd0);
        @(posedge clk);
        #1 check_eq("post_rst_accept", 32'(bus.COUNT), 32'd1);
        check_eq("post_rst_dig0", 32'(bus.DIG0), 32'd9);
        bus.KEY_ENTER_N = 1'b1;
        repeat (10) @(negedge clk);

`ifdef DIGIT_ENTRY_BKSP_EN
        press(1, 4'd0);
        press(0, 4'd6);
        press(0, 4'd1);
        press(0, 4'd4);
        press(2, 4'd0);
        check_eq("bksp_digits", 32'(digs()), 32'hFF61);
        check_eq("bksp_count", 32'(bus.COUNT), 32'd2);
        press(2, 4'd0);
        press(2, 4'd0);
        press(2, 4'd0);
        check_eq("bksp_underflow", 32'(bus.COUNT), 32'd0);
        check_eq("bksp_empty", 32'(digs()), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
